pll_reset_sequencer: RTL
========================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles `o_PLL_Reset` is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE, default 64: consecutive synchronized-lock-high cycles required before lock is accepted.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 12000 (1 ms at 12 MHz): maximum cycles in WAIT_LOCK before retry.
REQ-004 SHALL have parameter RESET_HOLD, default 256: cycles `o_Reset_n` stays low after lock is accepted.
REQ-005 SHALL have port `i_Clock`, input, 1 bit: 12 MHz reference clock (the PLL reference, never the PLL output).
REQ-006 SHALL have port `i_Reset_n`, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port `i_PLL_Lock`, input, 1 bit: PLL LOCK output, asynchronous to `i_Clock`.
REQ-008 SHALL have port `o_PLL_Reset`, output, 1 bit: active-high PLL reset request (drives the PLL RESET_N input through inversion).
REQ-009 SHALL have port `o_Reset_n`, output, 1 bit: active-low system reset for logic clocked by the PLL output.
REQ-010 SHALL have port `o_Locked`, output, 1 bit: high only in state RUN.
REQ-011 SHALL have port `o_Relock_Count`, output, 8 bits: saturating count of lock losses plus lock timeouts since reset.

Function
REQ-012 SHALL synchronize `i_PLL_Lock` through a 2-flop synchronizer; all lock decisions SHALL use the synchronized value only.
REQ-013 SHALL implement states PLL_RST, WAIT_LOCK, HOLD and RUN, using one shared down/up counter sized for the largest parameter.
REQ-014 PLL_RST: `o_PLL_Reset`=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
REQ-015 WAIT_LOCK: when synchronized lock is low, the stable counter SHALL clear; after LOCK_STABLE consecutive high cycles, go to HOLD.
REQ-016 WAIT_LOCK: if LOCK_TIMEOUT cycles elapse without acceptance, go to PLL_RST and increment `o_Relock_Count`.
REQ-017 HOLD: `o_Reset_n` stays 0 for RESET_HOLD cycles, then go to RUN; lock low during HOLD SHALL go to PLL_RST and increment `o_Relock_Count`.
REQ-018 RUN: `o_Reset_n`=1 and `o_Locked`=1; synchronized lock low for one cycle SHALL go to PLL_RST, increment `o_Relock_Count`, and drop `o_Reset_n` and `o_Locked` on the same registered edge.
REQ-019 `o_Relock_Count` SHALL saturate at 255 and never wrap.
REQ-020 `o_Reset_n` SHALL be 0 in every state except RUN; all outputs SHALL be registered (no combinational paths from inputs).
REQ-021 Lock rising and timeout expiring in the same cycle: timeout SHALL win unless LOCK_STABLE is satisfied on that cycle, in which case acceptance wins.

Reset
REQ-022 On `i_Reset_n`=0: state=PLL_RST, counter=0, synchronizer=0, `o_PLL_Reset`=1, `o_Reset_n`=0, `o_Locked`=0, `o_Relock_Count`=0, asynchronously.
REQ-023 Reset deassertion mid-sequence SHALL restart a full PLL_RST pulse of PLL_RST_CYCLES cycles.

Structure
REQ-024 The state enumeration and default parameter values SHALL live in a shared package, `addatone_clk_pkg`.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module, `sync_2ff`, reusable elsewhere in the codebase.

Verification
REQ-026 Bench SHALL check clean start: release reset, raise lock 20 cycles after `o_PLL_Reset` falls -> `o_PLL_Reset` high 16 cycles, `o_Reset_n` rises 2+64+256 cycles after lock rises, `o_Relock_Count`=0.
REQ-027 Bench SHALL check timeout: keep lock low -> `o_PLL_Reset` re-pulses every 16+12000 cycles and `o_Relock_Count` reaches 3 after 3 timeouts.
REQ-028 Bench SHALL check glitchy lock: in WAIT_LOCK, lock high 63 cycles, low 1, high 64 -> acceptance only after the second run.
REQ-029 Bench SHALL check lock loss in RUN: drop lock 1 cycle -> `o_Reset_n`=0 and `o_Locked`=0 within 3 cycles, PLL_RST re-entered, count=1.
REQ-030 Bench SHALL check saturation: force 300 timeouts with LOCK_TIMEOUT=8 -> `o_Relock_Count`=255.
REQ-031 Bench SHALL check mid-HOLD reset: assert `i_Reset_n`=0 at HOLD cycle 100 -> all outputs return to reset values immediately, and the full sequence repeats after release.

Source files
------------

// File: rtl/addatone_clk_pkg.sv
// Shared clocking definitions: sequencer state encoding, default timing
// parameters and small helpers used by the PLL reset sequencer.
package addatone_clk_pkg;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_STABLE    = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 12000;  // 1 ms at 12 MHz
  localparam int unsigned DEF_RESET_HOLD     = 256;
  localparam int unsigned RELOCK_W           = 8;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Bundle of the sequencer's lock input and reset/status outputs, for
// connecting the sequencer to the PLL and to the PLL-clocked logic.
interface pll_reset_sequencer_if;
  import addatone_clk_pkg::*;

  logic                pll_lock;
  logic                pll_reset;
  logic                reset_n;
  logic                locked;
  logic [RELOCK_W-1:0] relock_count;

  modport master (input pll_lock, output pll_reset, reset_n, locked, relock_count);
  modport slave  (output pll_lock, input pll_reset, reset_n, locked, relock_count);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing slow asynchronous level signals into
// the clk domain. Output is valid two clk edges after the input settles.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make meta_q and sync_q two real stages;
  // blocking ones here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for a stable lock, holds the downstream reset
// for a while, then releases it; any lock loss or timeout restarts the cycle.
module pll_reset_sequencer
  import addatone_clk_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned RESET_HOLD     = DEF_RESET_HOLD
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic                i_PLL_Lock,
  output logic                o_PLL_Reset,
  output logic                o_Reset_n,
  output logic                o_Locked,
  output logic [RELOCK_W-1:0] o_Relock_Count
);

  localparam int unsigned CNT_MAX =
    max_u(max_u(PLL_RST_CYCLES, LOCK_STABLE), max_u(LOCK_TIMEOUT, RESET_HOLD));
  localparam int unsigned CNT_W  = $clog2(CNT_MAX + 1);
  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (i_Clock),
    .rst_n (i_Reset_n),
    .d     (i_PLL_Lock),
    .q     (lock_s)
  );

  seq_state_e          state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [STAB_W-1:0]   stab_q,    stab_d;
  logic [RELOCK_W-1:0] relock_q,  relock_d;
  logic                pll_rst_q, pll_rst_d;
  logic                rst_n_q,   rst_n_d;
  logic                locked_q,  locked_d;

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    stab_d   = '0;
    relock_d = relock_q;

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        // Acceptance is tested first so a lock that completes its stable run
        // on the timeout cycle still wins.
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        if (lock_s && (stab_q == STAB_LAST)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d  = PLL_RST;
          cnt_d    = '0;
          relock_d = sat_inc(relock_q);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d  = PLL_RST;
          cnt_d    = '0;
          relock_d = sat_inc(relock_q);
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d  = PLL_RST;
          relock_d = sat_inc(relock_q);
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Outputs decode the next state so they change on the same edge as it.
    pll_rst_d = (state_d == PLL_RST);
    rst_n_d   = (state_d == RUN);
    locked_d  = (state_d == RUN);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      stab_q    <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      rst_n_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      relock_q  <= relock_d;
      pll_rst_q <= pll_rst_d;
      rst_n_q   <= rst_n_d;
      locked_q  <= locked_d;
    end
  end

  assign o_PLL_Reset    = pll_rst_q;
  assign o_Reset_n      = rst_n_q;
  assign o_Locked       = locked_q;
  assign o_Relock_Count = relock_q;

endmodule
